wash_sequencer: RTL and testbench
=================================

Name: wash_sequencer

Overview:
- Program execution stage of the washing-machine controller. It sits directly downstream of the mode-select stage.
- It consumes the selected wash mode (0..5) and steps through that mode's phases (wash, rinse, spin) on a 1 Hz tick.
- It produces the run state and finish pulse that the mode-select stage uses to lock selection and restore the default mode.

Parameters:
- WASH_T, 10, wash phase duration in ticks (1..255)
- RINSE_T, 6, rinse phase duration in ticks (1..255)
- SPIN_T, 4, spin phase duration in ticks (1..255); WASH_T+RINSE_T+SPIN_T must be ≤255

Ports:
- clk  input  1  system clock, all logic rising-edge
- rst_n  input  1  synchronous active-low reset
- tick  input  1  one-cycle 1 Hz time-base enable
- power_light  input  1  power on (1) / off (0), level
- start_pause  input  1  one-cycle pulse; start/pause/resume
- current_model  input  3  selected mode from mode-select stage
- run_state  output  2  0=idle, 1=running, 2=paused (3 never driven)
- finish  output  1  one-cycle pulse at program completion
- phase  output  2  0=none, 1=wash, 2=rinse, 3=spin
- phase_remain  output  8  ticks left in current phase
- remain_time  output  8  ticks left in whole program

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, rst_n. Polarity and synchronicity are fixed.
- Reset values: run_state=0, finish=0, phase=0, phase_remain=0, remain_time=0, latched mode=0.
  - rst_n=0 at a clock edge applies reset values.
  - power_light=0 at a clock edge does the same, including mid-run. rst_n has priority.
- Mode table (phase enable set):
  - 0 = W+R+S
  - 1 = W
  - 2 = W+R
  - 3 = R+S
  - 4 = R
  - 5 = S
  - 6 and 7 are treated as 0.
- State machine: IDLE (run_state 0), RUN (1), PAUSE (2). The finish pulse is issued on the RUN->IDLE transition.
- IDLE:
  - Condition: start_pause=1 and power_light=1.
  - Action: latch current_model and load the first enabled phase. phase_remain = that phase's duration; remain_time = sum of the enabled durations; run_state=1 next cycle.
  - A tick in the same cycle is ignored.
  - current_model is sampled only at start; later changes have no effect until the next start.
- RUN:
  - start_pause=1 -> PAUSE. Pause wins; a coincident tick is not applied.
  - Otherwise tick=1 decrements phase_remain and remain_time by 1.
  - When tick arrives with phase_remain==1, the next enabled phase is loaded (phase, phase_remain=duration) in the same update. remain_time still decrements.
  - If no further phase exists:
    - finish=1 for exactly that next cycle;
    - run_state=0, phase=0, phase_remain=0, remain_time=0.
- PAUSE:
  - Ticks are ignored and counters hold.
  - start_pause=1 -> RUN. A coincident tick is ignored.
- finish:
  - Registered and high for exactly one clk cycle per completed program.
  - Never asserted on power-off or reset abort.
- Phase order is always W, R, S, skipping disabled phases.
- Counters never underflow. remain_time always equals phase_remain plus the durations of the remaining enabled phases.
- All outputs are registered; there is no combinational path from input to output.

Test Plan:
- Mode 0, start, 20 ticks:
  - After start: phase=1, phase_remain=10, remain_time=20.
  - After 10 ticks: phase=2, phase_remain=6, remain_time=10.
  - After 16 ticks: phase=3, phase_remain=4.
  - After 20 ticks: finish high exactly 1 cycle, then run_state=0, all counters 0.
- Mode 5, start, 4 ticks -> phase=3 throughout, remain_time 4→0, finish pulse on the 4th tick, phase=0 after.
- Mode 0, 3 ticks, start_pause, 5 ticks, start_pause, 2 ticks:
  - Paused: run_state=2, remain_time held at 17.
  - After resume and 2 ticks: run_state=1, remain_time=15, phase_remain=5.
- Mode 2 mid-rinse, power_light=0 for 1 cycle -> next cycle all outputs at reset values, no finish pulse. start_pause while power_light=0 -> stays idle.
- current_model=7, start -> runs as mode 0 (remain_time=20). start_pause coincident with tick in RUN -> run_state=2, counters unchanged.
- rst_n=0 mid-run for 1 cycle -> next cycle all outputs at reset values. A tick in the reset cycle has no effect.

Source files
------------

// File: rtl/wash_sequencer.sv
// rtl/wash_sequencer.sv - wash program sequencer stepping W/R/S phases on a 1 Hz tick
module wash_sequencer #(
    parameter int WASH_T  = 10,
    parameter int RINSE_T = 6,
    parameter int SPIN_T  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       power_light,
    input  logic       start_pause,
    input  logic [2:0] current_model,
    output logic [1:0] run_state,
    output logic       finish,
    output logic [1:0] phase,
    output logic [7:0] phase_remain,
    output logic [7:0] remain_time
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    localparam logic [7:0] WASH_D  = 8'(WASH_T);
    localparam logic [7:0] RINSE_D = 8'(RINSE_T);
    localparam logic [7:0] SPIN_D  = 8'(SPIN_T);

    // enable bits: [0]=wash, [1]=rinse, [2]=spin
    function automatic logic [2:0] mode_en(input logic [2:0] m);
        case (m)
            3'd1:    return 3'b001;
            3'd2:    return 3'b011;
            3'd3:    return 3'b110;
            3'd4:    return 3'b010;
            3'd5:    return 3'b100;
            default: return 3'b111;
        endcase
    endfunction

    function automatic logic [7:0] phase_dur(input logic [1:0] p);
        case (p)
            2'd1:    return WASH_D;
            2'd2:    return RINSE_D;
            2'd3:    return SPIN_D;
            default: return 8'd0;
        endcase
    endfunction

    // first enabled phase strictly after 'after'; 0 when none is left
    function automatic logic [1:0] next_enabled(input logic [2:0] en, input logic [1:0] after);
        if (after < 2'd1 && en[0]) return 2'd1;
        if (after < 2'd2 && en[1]) return 2'd2;
        if (after < 2'd3 && en[2]) return 2'd3;
        return 2'd0;
    endfunction

    logic [2:0] mode_q;
    logic [2:0] start_en;
    logic [1:0] start_phase;
    logic [7:0] start_total;
    logic [1:0] next_phase;

    always_comb begin
        start_en    = mode_en(current_model);
        start_phase = next_enabled(start_en, 2'd0);
        start_total = (start_en[0] ? WASH_D : 8'd0)
                    + (start_en[1] ? RINSE_D : 8'd0)
                    + (start_en[2] ? SPIN_D : 8'd0);
        next_phase  = next_enabled(mode_en(mode_q), phase);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !power_light) begin
            run_state    <= ST_IDLE;
            finish       <= 1'b0;
            phase        <= 2'd0;
            phase_remain <= 8'd0;
            remain_time  <= 8'd0;
            mode_q       <= 3'd0;
        end else begin
            finish <= 1'b0;
            case (run_state)
                ST_IDLE: begin
                    if (start_pause) begin
                        mode_q       <= current_model;
                        phase        <= start_phase;
                        phase_remain <= phase_dur(start_phase);
                        remain_time  <= start_total;
                        run_state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (start_pause) begin
                        run_state <= ST_PAUSE;
                    end else if (tick) begin
                        if (remain_time != 8'd0) remain_time <= remain_time - 8'd1;
                        if (phase_remain > 8'd1) begin
                            phase_remain <= phase_remain - 8'd1;
                        end else if (next_phase != 2'd0) begin
                            phase        <= next_phase;
                            phase_remain <= phase_dur(next_phase);
                        end else begin
                            finish       <= 1'b1;
                            run_state    <= ST_IDLE;
                            phase        <= 2'd0;
                            phase_remain <= 8'd0;
                            remain_time  <= 8'd0;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (start_pause) run_state <= ST_RUN;
                end
                default: run_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wash_sequencer.sv
// tb/tb_wash_sequencer.sv - randomized and directed check of wash_sequencer against a phase-queue model
module tb_wash_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, tick, power_light, start_pause;
    logic [2:0] current_model;
    logic [1:0] run_state;
    logic       finish;
    logic [1:0] phase;
    logic [7:0] phase_remain;
    logic [7:0] remain_time;

    always #5 clk = ~clk;

    wash_sequencer #(.WASH_T(10), .RINSE_T(6), .SPIN_T(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .power_light  (power_light),
        .start_pause  (start_pause),
        .current_model(current_model),
        .run_state    (run_state),
        .finish       (finish),
        .phase        (phase),
        .phase_remain (phase_remain),
        .remain_time  (remain_time)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // model: program = queue of pending phases, plus the active one and its countdown
    string mode_str [8] = '{"WRS", "W", "WR", "RS", "R", "S", "WRS", "WRS"};
    int m_st = 0, m_cur = 0, m_prem = 0, m_fin = 0;
    int m_q[$];

    function automatic int dur_of(input int p);
        case (p)
            1: return 10;
            2: return 6;
            3: return 4;
            default: return 0;
        endcase
    endfunction

    function automatic int m_remain();
        int s = m_prem;
        foreach (m_q[i]) s += dur_of(m_q[i]);
        return s;
    endfunction

    task automatic model_start(input logic [2:0] md);
        string s = mode_str[md];
        m_q.delete();
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == "W") m_q.push_back(1);
            else if (s[i] == "R") m_q.push_back(2);
            else m_q.push_back(3);
        end
        m_cur  = m_q.pop_front();
        m_prem = dur_of(m_cur);
        m_st   = 1;
    endtask

    task automatic step(input logic r, input logic pw, input logic tk, input logic sp, input logic [2:0] md);
        rst_n = r; power_light = pw; tick = tk; start_pause = sp; current_model = md;
        @(posedge clk);
        m_fin = 0;
        if (!r || !pw) begin
            m_st = 0; m_cur = 0; m_prem = 0; m_q.delete();
        end else if (m_st == 0) begin
            if (sp) model_start(md);
        end else if (m_st == 1) begin
            if (sp) m_st = 2;
            else if (tk) begin
                if (m_prem > 1) m_prem--;
                else if (m_q.size() > 0) begin
                    m_cur = m_q.pop_front(); m_prem = dur_of(m_cur);
                end else begin
                    m_fin = 1; m_st = 0; m_cur = 0; m_prem = 0;
                end
            end
        end else if (sp) m_st = 1;
        #1;
        chk("run_state", 32'(run_state), m_st);
        chk("finish", 32'(finish), m_fin);
        chk("phase", 32'(phase), m_cur);
        chk("phase_remain", 32'(phase_remain), m_prem);
        chk("remain_time", 32'(remain_time), m_remain());
    endtask

    initial begin
        step(0, 1, 0, 0, 0);
        step(0, 1, 1, 1, 3);
        chk("reset_state", 32'(run_state), 0);

        // mode 0 full program
        step(1, 1, 0, 1, 0);
        chk("m0_start_rem", 32'(remain_time), 20);
        chk("m0_start_prem", 32'(phase_remain), 10);
        for (int i = 1; i <= 20; i++) begin
            step(1, 1, 1, 0, 3'(i % 8));
            if (i == 10) chk("m0_t10_phase", 32'(phase), 2);
            if (i == 16) chk("m0_t16_phase", 32'(phase), 3);
            if (i == 20) chk("m0_finish", 32'(finish), 1);
            step(1, 1, 0, 0, 0);
        end
        chk("m0_done_state", 32'(run_state), 0);

        // mode 5 spin only
        step(1, 1, 1, 1, 5);
        chk("m5_phase", 32'(phase), 3);
        for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 0);
        chk("m5_finish", 32'(finish), 1);
        step(1, 1, 0, 0, 0);
        chk("m5_phase_after", 32'(phase), 0);

        // pause / resume
        step(1, 1, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0);
        step(1, 1, 0, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 1, 1, 0, 0);
        chk("pause_state", 32'(run_state), 2);
        chk("pause_rem", 32'(remain_time), 17);
        step(1, 1, 0, 1, 0);
        for (int i = 0; i < 2; i++) step(1, 1, 1, 0, 0);
        chk("resume_rem", 32'(remain_time), 15);
        chk("resume_prem", 32'(phase_remain), 5);

        // power off mid-rinse in mode 2
        step(0, 1, 0, 0, 0);
        step(1, 1, 0, 1, 2);
        for (int i = 0; i < 12; i++) step(1, 1, 1, 0, 0);
        chk("m2_rinse", 32'(phase), 2);
        step(1, 0, 1, 0, 0);
        chk("poweroff_state", 32'(run_state), 0);
        chk("poweroff_rem", 32'(remain_time), 0);
        step(1, 0, 0, 1, 0);
        chk("off_start_idle", 32'(run_state), 0);

        // mode 7 aliases mode 0; pause beats tick
        step(1, 1, 0, 1, 7);
        chk("m7_rem", 32'(remain_time), 20);
        step(1, 1, 1, 1, 0);
        chk("pause_tick_state", 32'(run_state), 2);
        chk("pause_tick_rem", 32'(remain_time), 20);
        step(1, 1, 0, 1, 0);
        step(1, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        chk("rst_mid_state", 32'(run_state), 0);
        chk("rst_mid_prem", 32'(phase_remain), 0);

        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 299) != 0), ($urandom_range(0, 149) != 0),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 24) == 0),
                 3'($urandom_range(0, 7)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
